// File: rtl/btn_pkg.sv
// Shared types and board defaults for the push-button conditioner.
// Build option: BTN_LONGPRESS_EN enables the long-press hold counter in button_debounce.
package btn_pkg;

    // Debounce FSM states: two stable levels, each with a "waiting to confirm" partner
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Defaults for the 12 MHz board clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 12000;     // 1 ms
    localparam int DEFAULT_LONG_CYCLES     = 12000000;  // 1 s
    localparam int DEFAULT_CNT_W           = 8;

    // Debounce timer width; the extra bit keeps DEBOUNCE_CYCLES=1 at a legal width
    function automatic int timer_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button conditioner signal bundle: raw pin in, conditioned level/events out.
// master = the conditioner, slave = the logic consuming the button events.
interface button_debounce_if #(
    parameter int CNT_W = 8
);
    logic             btn_raw;
    logic             btn_level;
    logic             press_pulse;
    logic             release_pulse;
    logic             long_pulse;
    logic [CNT_W-1:0] press_count;

    modport master (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output press_count
    );

    modport slave (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  press_count
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, reset to 0.
// One independent flop pair per bit; no cross-bit coherence is implied.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             hwclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            // First flop may go metastable; second gives it a full cycle to settle
            always_ff @(posedge hwclk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce, and emit level, press/release
// pulses, a wrapping press counter and (with BTN_LONGPRESS_EN) a long-press pulse.
// Without BTN_LONGPRESS_EN the hold counter is not built and long_pulse is 0.
module button_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic              hwclk,
    input  logic              rst_n,
    button_debounce_if.master bus
);

    localparam int TIMER_W = timer_width(DEBOUNCE_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("button_debounce: DEBOUNCE_CYCLES must be >= 1");
        end
        if (LONG_CYCLES < 1) begin : g_bad_long
            $error("button_debounce: LONG_CYCLES must be >= 1");
        end
    endgenerate

    logic btn_s;

    btn_state_t       state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic             level_reg, level_next;
    logic             press_pulse_reg, press_pulse_next;
    logic             release_pulse_reg, release_pulse_next;
    logic [CNT_W-1:0] count_reg, count_next;

    sync_2ff #(.WIDTH(1)) u_sync (
        .hwclk (hwclk),
        .rst_n (rst_n),
        .d     (bus.btn_raw),
        .q     (btn_s)
    );

    // State, debounce timer and all event outputs are registered together
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= RELEASED;
            timer_reg         <= '0;
            level_reg         <= 1'b0;
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
            count_reg         <= '0;
        end else begin
            state_reg         <= state_next;
            timer_reg         <= timer_next;
            level_reg         <= level_next;
            press_pulse_reg   <= press_pulse_next;
            release_pulse_reg <= release_pulse_next;
            count_reg         <= count_next;
        end
    end

    // An edge is accepted only after btn_s holds the new value for the whole timer run;
    // any return to the old value abandons the attempt without an event
    always_comb begin
        state_next         = state_reg;
        timer_next         = timer_reg;
        level_next         = level_reg;
        press_pulse_next   = 1'b0;
        release_pulse_next = 1'b0;
        count_next         = count_reg;
        case (state_reg)
            RELEASED: begin
                if (btn_s) begin
                    state_next = PRESS_WAIT;
                    timer_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_next = RELEASED;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next       = PRESSED;
                    level_next       = 1'b1;
                    press_pulse_next = 1'b1;
                    count_next       = count_reg + 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_next = RELEASE_WAIT;
                    timer_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_next = PRESSED;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next         = RELEASED;
                    level_next         = 1'b0;
                    release_pulse_next = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next = RELEASED;
            end
        endcase
    end

    assign bus.btn_level     = level_reg;
    assign bus.press_pulse   = press_pulse_reg;
    assign bus.release_pulse = release_pulse_reg;
    assign bus.press_count   = count_reg;

`ifdef BTN_LONGPRESS_EN
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              fired_reg, fired_next;
    logic              long_pulse_reg, long_pulse_next;
    logic              holding;

    // Release bounces do not restart the hold time, so RELEASE_WAIT keeps counting
    assign holding = (state_reg == PRESSED) || (state_reg == RELEASE_WAIT);

    // Hold time, once-per-press flag and long pulse registers
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg       <= '0;
            fired_reg      <= 1'b0;
            long_pulse_reg <= 1'b0;
        end else begin
            hold_reg       <= hold_next;
            fired_reg      <= fired_next;
            long_pulse_reg <= long_pulse_next;
        end
    end

    // Restart on each accepted press; saturate at the last count and fire only once
    always_comb begin
        hold_next       = hold_reg;
        fired_next      = fired_reg;
        long_pulse_next = 1'b0;
        if (press_pulse_next) begin
            hold_next  = '0;
            fired_next = 1'b0;
        end else if (holding) begin
            if (hold_reg == HOLD_LAST) begin
                if (!fired_reg) begin
                    long_pulse_next = 1'b1;
                    fired_next      = 1'b1;
                end
            end else begin
                hold_next = hold_reg + 1'b1;
            end
        end
    end

    assign bus.long_pulse = long_pulse_reg;
`else
    assign bus.long_pulse = 1'b0;
`endif

endmodule
